// File: rtl/symmetric_fir_pkg.sv
// Shared defaults and derived widths for the symmetric FIR filter.
// Stage widths grow one guard bit per arithmetic step so nothing ever truncates.
package symmetric_fir_pkg;

  localparam int COEFF_NUM   = 6;
  localparam int COEFF_WIDTH = 8;
  localparam int DATA_DELAY  = 12;
  localparam int DATA_WIDTH  = 12;

  localparam int STAGE1_WIDTH = DATA_WIDTH + 1;
  localparam int STAGE2_WIDTH = STAGE1_WIDTH + COEFF_WIDTH + 1;
  localparam int STAGE3_WIDTH = STAGE2_WIDTH + 1;
  localparam int OUTPUT_WIDTH = STAGE3_WIDTH + 2;

  // Every delay-line slot must have exactly one mirror partner.
  function automatic bit delay_matches(input int coeff_num, input int data_delay);
    return data_delay == 2 * coeff_num;
  endfunction

  // Bits needed to sum n_terms values without overflow.
  function automatic int sum_growth(input int n_terms);
    int bits;
    bits = 0;
    while ((1 << bits) < n_terms) bits++;
    return bits;
  endfunction

  localparam bit DEFAULT_DELAY_OK = delay_matches(COEFF_NUM, DATA_DELAY);

endpackage

// File: rtl/symmetric_fir_filter_if.sv
// Sample/coefficient bus between a stimulus or control master and the FIR filter.
interface symmetric_fir_filter_if #(
  parameter int DATA_WIDTH   = symmetric_fir_pkg::DATA_WIDTH,
  parameter int COEFF_WIDTH  = symmetric_fir_pkg::COEFF_WIDTH,
  parameter int OUTPUT_WIDTH = symmetric_fir_pkg::OUTPUT_WIDTH
);

  logic                           load;
  logic signed [COEFF_WIDTH-1:0]  coeff_value;
  logic signed [DATA_WIDTH-1:0]   noisy_signal;
  logic signed [OUTPUT_WIDTH-1:0] filtered_signal;

  modport master (
    output load,
    output coeff_value,
    output noisy_signal,
    input  filtered_signal
  );

  modport slave (
    input  load,
    input  coeff_value,
    input  noisy_signal,
    output filtered_signal
  );

endinterface

// File: rtl/symmetric_fir_tap_pair.sv
// One symmetric tap pair: registered pre-add of mirrored samples, then registered multiply.
module symmetric_fir_tap_pair #(
  parameter int DATA_WIDTH  = symmetric_fir_pkg::DATA_WIDTH,
  parameter int COEFF_WIDTH = symmetric_fir_pkg::COEFF_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        clr,
  input  logic signed [DATA_WIDTH-1:0]                sample_near,
  input  logic signed [DATA_WIDTH-1:0]                sample_far,
  input  logic signed [COEFF_WIDTH-1:0]               coeff,
  output logic signed [DATA_WIDTH+COEFF_WIDTH+1:0]    product
);

  import symmetric_fir_pkg::*;

  localparam int PRE_W  = DATA_WIDTH + 1;
  localparam int PROD_W = PRE_W + COEFF_WIDTH + 1;

  logic signed [PRE_W-1:0] pre_sum;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pre_sum <= '0;
      product <= '0;
    end else begin
      pre_sum <= PRE_W'(sample_near) + PRE_W'(sample_far);
      // Coefficient is sampled live, so a reload reaches this multiply on the next edge.
      product <= PROD_W'(pre_sum) * PROD_W'(coeff);
    end
  end

endmodule

// File: rtl/symmetric_fir_filter.sv
// Linear-phase FIR: serial coefficient bank, delay line, COEFF_NUM tap pairs and a
// two-level registered adder tree (pairwise sums, then final sum into the output).
module symmetric_fir_filter #(
  parameter int COEFF_NUM    = symmetric_fir_pkg::COEFF_NUM,
  parameter int COEFF_WIDTH  = symmetric_fir_pkg::COEFF_WIDTH,
  parameter int DATA_DELAY   = symmetric_fir_pkg::DATA_DELAY,
  parameter int DATA_WIDTH   = symmetric_fir_pkg::DATA_WIDTH,
  parameter int OUTPUT_WIDTH = symmetric_fir_pkg::OUTPUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  symmetric_fir_filter_if.slave bus
);

  import symmetric_fir_pkg::*;

  localparam int PROD_W   = DATA_WIDTH + COEFF_WIDTH + 2;
  localparam int PAIR_W   = PROD_W + 1;
  localparam int NUM_SUMS = (COEFF_NUM + 1) / 2;

  if (!delay_matches(COEFF_NUM, DATA_DELAY)) begin : g_bad_delay
    $error("symmetric_fir_filter: DATA_DELAY must equal 2*COEFF_NUM");
  end

  if (OUTPUT_WIDTH < PAIR_W + sum_growth(NUM_SUMS)) begin : g_bad_width
    $error("symmetric_fir_filter: OUTPUT_WIDTH too narrow for full precision");
  end

  logic signed [COEFF_WIDTH-1:0]  coeff    [COEFF_NUM];
  logic signed [DATA_WIDTH-1:0]   x        [DATA_DELAY];
  logic signed [PROD_W-1:0]       prod     [COEFF_NUM];
  logic signed [PAIR_W-1:0]       pair_sum [NUM_SUMS];
  logic signed [OUTPUT_WIDTH-1:0] tree_sum;
  logic signed [OUTPUT_WIDTH-1:0] filtered_q;

  // New values enter at the centre taps and walk outward toward coeff[0].
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < COEFF_NUM; k++) coeff[k] <= '0;
    end else if (bus.load) begin
      for (int k = 0; k < COEFF_NUM - 1; k++) coeff[k] <= coeff[k+1];
      coeff[COEFF_NUM-1] <= bus.coeff_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int k = 0; k < DATA_DELAY; k++) x[k] <= '0;
    end else begin
      x[0] <= bus.noisy_signal;
      for (int k = 1; k < DATA_DELAY; k++) x[k] <= x[k-1];
    end
  end

  for (genvar k = 0; k < COEFF_NUM; k++) begin : g_pair
    symmetric_fir_tap_pair #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH)
    ) u_pair (
      .clk         (clk),
      .clr         (clr),
      .sample_near (x[k]),
      .sample_far  (x[DATA_DELAY-1-k]),
      .coeff       (coeff[k]),
      .product     (prod[k])
    );
  end

  // An odd tap-pair count leaves the last product to pass through widened.
  for (genvar j = 0; j < NUM_SUMS; j++) begin : g_sum
    if (2 * j + 1 < COEFF_NUM) begin : g_two
      always_ff @(posedge clk) begin
        if (!clr) pair_sum[j] <= '0;
        else      pair_sum[j] <= PAIR_W'(prod[2*j]) + PAIR_W'(prod[2*j+1]);
      end
    end else begin : g_one
      always_ff @(posedge clk) begin
        if (!clr) pair_sum[j] <= '0;
        else      pair_sum[j] <= PAIR_W'(prod[2*j]);
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < NUM_SUMS; j++) begin
      tree_sum = tree_sum + OUTPUT_WIDTH'(pair_sum[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) filtered_q <= '0;
    else      filtered_q <= tree_sum;
  end

  assign bus.filtered_signal = filtered_q;

endmodule

// File: tb/tb_symmetric_fir_filter.sv
// Directed bench for symmetric_fir_filter: reset, impulse response, DC extremes,
// mid-stream coefficient reload and mid-stream reset, all against hand-derived values.
module tb_symmetric_fir_filter;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  longint prev_out;
  longint cur_out;

  symmetric_fir_filter_if bus ();

  symmetric_fir_filter dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the active edge.
  task automatic applyStimulus(input logic ld, input int cv, input int sample);
    bus.load         = ld;
    bus.coeff_value  = 8'(cv);
    bus.noisy_signal = 12'(sample);
    @(posedge clk);
    #1;
  endtask

  function automatic longint outNow();
    return longint'(bus.filtered_signal);
  endfunction

  function automatic longint impulseTap(input int k);
    return longint'(((k < 11 - k) ? k : 11 - k) + 1);
  endfunction

  task automatic loadRamp(input int sample);
    for (int v = 1; v <= 6; v++) applyStimulus(1'b1, v, sample);
  endtask

  task automatic loadUniform(input int value, input int sample);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, value, sample);
  endtask

  task automatic holdSample(input int sample, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 0, sample);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr              = 1'b0;
    bus.load         = 1'b0;
    bus.coeff_value  = '0;
    bus.noisy_signal = '0;

    // Reset holds everything at zero even while load and samples are busy.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 77, 1234);
      checkOutput("reset_hold", outNow(), 0);
    end
    clr = 1'b1;

    // Coefficients were cleared, so an impulse with no load yields nothing.
    holdSample(0, 2);
    applyStimulus(1'b0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput("zero_coeff_impulse", outNow(), 0);
    end

    $display("[TB] impulse response with coefficients 1..6");
    loadRamp(0);
    holdSample(0, 4);
    applyStimulus(1'b0, 0, 1);
    holdSample(0, 3);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput($sformatf("impulse_h%0d", k), outNow(), impulseTap(k));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput("impulse_tail", outNow(), 0);
    end

    $display("[TB] reset in the middle of an impulse");
    loadRamp(0);
    holdSample(0, 4);
    applyStimulus(1'b0, 0, 1);
    holdSample(0, 3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput($sformatf("pre_reset_h%0d", k), outNow(), impulseTap(k));
    end
    clr = 1'b0;
    applyStimulus(1'b0, 0, 0);
    checkOutput("mid_reset_edge", outNow(), 0);
    clr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput("post_reset_quiet", outNow(), 0);
    end
    applyStimulus(1'b0, 0, 1);
    holdSample(0, 9);
    checkOutput("post_reset_no_coeff", outNow(), 0);

    $display("[TB] DC extremes");
    loadUniform(-128, -2048);
    holdSample(-2048, 20);
    checkOutput("dc_neg_neg", outNow(), 64'sd3145728);

    applyStimulus(1'b1, 5, 2047);
    applyStimulus(1'b1, 9, 2047);
    loadUniform(127, 2047);
    holdSample(2047, 20);
    checkOutput("dc_pos_pos_extra_load", outNow(), 64'sd3119628);

    loadUniform(-128, 2047);
    holdSample(2047, 20);
    checkOutput("dc_neg_coeff_pos_in", outNow(), -64'sd3144192);

    $display("[TB] coefficient reload while streaming");
    loadUniform(1, 100);
    holdSample(100, 20);
    checkOutput("reload_before", outNow(), 1200);
    prev_out = outNow();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2, 100);
      cur_out = outNow();
      checkOutput("reload_monotonic", longint'(cur_out >= prev_out), 1);
      prev_out = cur_out;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 0, 100);
      cur_out = outNow();
      checkOutput("reload_monotonic", longint'(cur_out >= prev_out), 1);
      prev_out = cur_out;
    end
    checkOutput("reload_after", outNow(), 2400);
    holdSample(100, 5);
    checkOutput("reload_stays", outNow(), 2400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/symmetric_fir_filter.md
Name: symmetric_fir_filter

Overview:
- Pipelined, linear-phase (symmetric) FIR filter with runtime-loadable coefficients.
- One DATA_WIDTH sample is accepted every clock. Symmetric tap pairs are pre-added before the multiply, so only COEFF_NUM multipliers serve 2*COEFF_NUM taps.
- Sits in the signal-conditioning datapath between a sample source (ADC or stimulus) and downstream processing. A control master shifts coefficients in serially.

Parameters:
- COEFF_NUM, 6: number of unique coefficients, i.e. number of symmetric tap pairs.
- COEFF_WIDTH, 8: signed coefficient width.
- DATA_DELAY, 12: delay-line length in samples. Must equal 2*COEFF_NUM.
- DATA_WIDTH, 12: signed input sample width.
- OUTPUT_WIDTH, 25: signed output width. Default equals DATA_WIDTH+COEFF_WIDTH+5.

Ports:
- clk, input, 1: single clock. All logic is sampled on the rising edge.
- clr, input, 1: synchronous, active-low reset.
- load, input, 1: coefficient shift enable.
- coeff_value, input, COEFF_WIDTH: signed coefficient for serial load.
- noisy_signal, input, DATA_WIDTH: signed input sample.
- filtered_signal, output, OUTPUT_WIDTH: signed filter result. Registered output.

Behaviour:
- Reset: on a rising edge with clr=0, all state clears to 0. This covers the coefficient bank, delay line, all pipeline registers and filtered_signal. Reset has priority over load.
- Coefficient bank: coeff[0..COEFF_NUM-1].
  - On an edge with load=1, the bank shifts: coeff[COEFF_NUM-1] <= coeff_value and coeff[k] <= coeff[k+1].
  - After exactly COEFF_NUM load cycles, the first value loaded sits in coeff[0] (outermost taps) and the last in coeff[COEFF_NUM-1] (centre taps).
  - With load=0 the bank holds.
  - Extra load cycles keep shifting; only the last COEFF_NUM values remain.
- Delay line: x[0..DATA_DELAY-1] shifts on every non-reset edge, independent of load: x[0] <= noisy_signal, x[k] <= x[k-1].
- Effective impulse response: h(k) = coeff[min(k, DATA_DELAY-1-k)].
- Pipeline (each stage registered):
  - S1: p[k] = x[k] + x[DATA_DELAY-1-k], sign-extended to DATA_WIDTH+1.
  - S2: m[k] = p[k] * coeff[k], signed, DATA_WIDTH+COEFF_WIDTH+2 bits wide (one guard bit).
  - S3: adjacent products are summed pairwise, giving COEFF_NUM/2 sums of width S2+1.
  - S4: all S3 sums are summed into filtered_signal, width S3+2.
  - S3 and S4 generalise to a balanced adder tree. Output width must hold the full-precision worst case. No saturation, rounding or truncation.
- Latency: a sample captured into x[0] at edge t contributes h(k)*sample to filtered_signal after edge t+4+k.
- Coefficient changes during streaming take effect at the S2 multiply on the next edge. There is no flush, and old partial products already in flight complete with the old values.
- Reset mid-stream: the pipeline empties. filtered_signal is 0 after the reset edge and stays 0 until new non-zero data propagates through.
- All arithmetic is two's-complement signed.

Decomposition:
- Package symmetric_fir_pkg holds:
  - Default width parameters.
  - Derived localparams: STAGE1_WIDTH = DATA_WIDTH+1, STAGE2_WIDTH = STAGE1_WIDTH+COEFF_WIDTH+1, STAGE3_WIDTH = STAGE2_WIDTH+1, OUTPUT_WIDTH = STAGE3_WIDTH+2.
  - An elaboration check that DATA_DELAY == 2*COEFF_NUM.
- One sub-module is natural: symmetric_fir_tap_pair.
  - Registered pre-add followed by registered multiply for one pair.
  - Instantiated COEFF_NUM times in a generate loop.
  - The top level keeps the coefficient bank, delay line and adder tree.

Test Plan:
- Reset: drive arbitrary inputs with clr=0 for 3 cycles -> filtered_signal=0 on every edge. Coefficients read back 0, so a later impulse with no load gives all-zero output.
- Impulse: load 1,2,3,4,5,6, then one sample of 1 followed by zeros -> starting 4 edges after capture, output is 1,2,3,4,5,6,6,5,4,3,2,1, then 0 forever.
- DC negative extreme: coefficients all -128, input held at -2048 -> settles at 3145728 with no overflow.
- DC positive: coefficients all 127, input held at 2047 -> settles at 3119628. Also coefficients all -128 with input 2047 -> settles at -3144192.
- Reload mid-stream: with constant input 100 and coefficients all 1 (output 1200), shift in six 2's while input continues -> output moves monotonically to 2400 and stays there. The delay line is not disturbed.
- Reset mid-operation: during the impulse test, assert clr=0 for one edge -> output is 0 on the next edge and stays 0 while input stays 0. Coefficients must be reloaded after reset.
